// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg
//   Shared types and constants for the instruction-memory loader.
//   loader_state_t : frame-parsing FSM states
//   SYNC_BYTE_DEF  : default frame start marker
//   BYTE_W/WORD_W/LEN_W : widths of a stream byte, a memory word, the length field
// ---------------------------------------------------------------------------
package imem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN0,
      LEN1,
      DATA,
      CSUM,
      DONE,
      ERROR
   } loader_state_t;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
   localparam int         BYTE_W        = 8;
   localparam int         WORD_W        = 32;
   localparam int         LEN_W         = 16;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// ---------------------------------------------------------------------------
// imem_loader_byte_packer
//   Packs a little-endian byte stream into 32-bit words.
//   clk, rst      : clock, asynchronous active-low reset
//   clear         : force the byte index back to 0 (start of a new frame)
//   byte_valid    : accept byte_data this cycle
//   byte_data     : incoming byte
//   byte_idx      : position (0..3) the next accepted byte will occupy
//   word_ready    : one-cycle pulse, the cycle after the 4th byte is accepted
//   word_data     : packed word, valid while word_ready is high (held after)
// ---------------------------------------------------------------------------
module imem_loader_byte_packer
   import imem_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              byte_valid,
   input  logic [BYTE_W-1:0] byte_data,
   output logic [1:0]        byte_idx,
   output logic              word_ready,
   output logic [WORD_W-1:0] word_data
);

   logic [1:0]        idx_q,   idx_d;
   logic [23:0]       sr_q,    sr_d;
   logic              ready_q, ready_d;
   logic [WORD_W-1:0] word_q,  word_d;

   always_comb begin
      idx_d   = idx_q;
      sr_d    = sr_q;
      ready_d = 1'b0;
      word_d  = word_q;
      if (clear) begin
         idx_d = 2'd0;
      end else if (byte_valid) begin
         if (idx_q == 2'd3) begin
            // sr_q holds bytes 0..2 with byte 0 in the low lane
            word_d  = {byte_data, sr_q};
            ready_d = 1'b1;
            idx_d   = 2'd0;
         end else begin
            // shift in from the top so earlier bytes settle toward bit 0
            sr_d  = {byte_data, sr_q[23:8]};
            idx_d = idx_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_q   <= 2'd0;
         sr_q    <= 24'd0;
         ready_q <= 1'b0;
         word_q  <= '0;
      end else begin
         idx_q   <= idx_d;
         sr_q    <= sr_d;
         ready_q <= ready_d;
         word_q  <= word_d;
      end
   end

   assign byte_idx   = idx_q;
   assign word_ready = ready_q;
   assign word_data  = word_q;

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Receives a framed byte stream (SYNC, LEN_LO, LEN_HI, 4N data bytes, CSUM)
//   and writes the payload into instruction memory one word at a time. The
//   core is held (core_run=0) until a frame's XOR checksum verifies.
//   clk, rst        : clock, asynchronous active-low reset
//   in_valid/in_data/in_ready : byte stream handshake
//   restart         : pulse, leaves DONE/ERROR for IDLE
//   wr_en/wr_addr/wr_data : instruction memory write port
//   core_run        : core may fetch
//   done / error    : frame accepted / frame rejected
// ---------------------------------------------------------------------------
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int              ADDR_W    = 10,
   parameter logic [7:0]      SYNC_BYTE = SYNC_BYTE_DEF,
   parameter int              BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   input  logic              restart,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              core_run,
   output logic              done,
   output logic              error
);

   localparam logic [LEN_W:0]    MAX_WORDS = (LEN_W+1)'(2**ADDR_W);
   localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

   loader_state_t     state_q, state_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  word_cnt_q, word_cnt_d;
   logic [7:0]        csum_q, csum_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              run_q, run_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic              xfer;
   logic              pk_clear;
   logic              pk_valid;
   logic [1:0]        pk_idx;
   logic              pk_ready;
   logic [31:0]       pk_word;
   logic [LEN_W-1:0]  len_new;

   assign in_ready = (state_q != DONE) && (state_q != ERROR);
   assign xfer     = in_valid && in_ready;
   assign len_new  = {in_data, len_q[7:0]};
   assign pk_clear = (state_q == IDLE) && xfer && (in_data == SYNC_BYTE);
   assign pk_valid = (state_q == DATA) && xfer;

   imem_loader_byte_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .clear      (pk_clear),
      .byte_valid (pk_valid),
      .byte_data  (in_data),
      .byte_idx   (pk_idx),
      .word_ready (pk_ready),
      .word_data  (pk_word)
   );

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      word_cnt_d = word_cnt_q;
      csum_d     = csum_q;
      addr_d     = addr_q;
      run_d      = run_q;
      done_d     = done_q;
      err_d      = err_q;

      // address advances once the word currently on the port has been written
      if (pk_ready) addr_d = addr_q + ADDR_W'(1);

      unique case (state_q)
         IDLE: begin
            if (xfer && (in_data == SYNC_BYTE)) begin
               state_d    = LEN0;
               run_d      = 1'b0;
               done_d     = 1'b0;
               err_d      = 1'b0;
               csum_d     = 8'h00;
               word_cnt_d = '0;
               addr_d     = BASE;
            end
         end
         LEN0: begin
            if (xfer) begin
               len_d[7:0] = in_data;
               state_d    = LEN1;
            end
         end
         LEN1: begin
            if (xfer) begin
               len_d = len_new;
               if ({1'b0, len_new} > MAX_WORDS) begin
                  state_d = ERROR;
                  err_d   = 1'b1;
                  run_d   = 1'b0;
               end else if (len_new == '0) begin
                  state_d = CSUM;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (xfer) begin
               csum_d = csum_q ^ in_data;
               if (pk_idx == 2'd3) begin
                  word_cnt_d = word_cnt_q + LEN_W'(1);
                  if (word_cnt_q == len_q - LEN_W'(1)) state_d = CSUM;
               end
            end
         end
         CSUM: begin
            if (xfer) begin
               if (in_data == csum_q) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  run_d   = 1'b1;
               end else begin
                  state_d = ERROR;
                  err_d   = 1'b1;
                  run_d   = 1'b0;
               end
            end
         end
         DONE, ERROR: begin
            // core_run deliberately untouched: a running core keeps running
            // until the next sync byte arrives
            if (restart) begin
               state_d = IDLE;
               done_d  = 1'b0;
               err_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         len_q      <= '0;
         word_cnt_q <= '0;
         csum_q     <= 8'h00;
         addr_q     <= BASE;
         run_q      <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         word_cnt_q <= word_cnt_d;
         csum_q     <= csum_d;
         addr_q     <= addr_d;
         run_q      <= run_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign wr_en    = pk_ready;
   assign wr_data  = pk_word;
   assign wr_addr  = addr_q;
   assign core_run = run_q;
   assign done     = done_q;
   assign error    = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//   Self-checking bench for imem_loader: a table of whole frames with their
//   expected writes and final flags, plus hand-written multi-cycle sequences
//   (gaps/junk/restart, immediate overflow, 1024-word boundary, resets).
//   Expected writes are queued when a frame is driven and popped by a
//   monitor whenever wr_en is seen.
// ---------------------------------------------------------------------------
module tb_imem_loader;

   localparam int ADDR_W = 10;

   logic              clk      = 1'b0;
   logic              rst      = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data  = 8'h00;
   logic              restart  = 1'b0;
   logic              in_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic              core_run;
   logic              done;
   logic              error;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string             name;
      logic [127:0]      bytes;   // frame bytes, first byte in the most significant used lane
      int                nb;
      logic              exp_done;
      logic              exp_err;
      logic              exp_run;
      int                nw;
      logic [1:0][9:0]   wa;
      logic [1:0][31:0]  wd;
   } vec_t;

   typedef struct {
      logic [9:0]  a;
      logic [31:0] d;
   } wr_t;

   vec_t vecs[6];
   wr_t  exp_q[$];
   wr_t  mon_e;

   imem_loader #(.ADDR_W(ADDR_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .restart  (restart),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .core_run (core_run),
      .done     (done),
      .error    (error)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // scoreboard consumer: every write must match the head of the queue
   always @(negedge clk) begin
      if (rst && wr_en) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                     wr_addr, wr_data);
         end else begin
            mon_e = exp_q.pop_front();
            $display("write addr=0x%03h data=0x%08h", wr_addr, wr_data);
            chk("wr_addr", 32'(wr_addr), 32'(mon_e.a));
            chk("wr_data", wr_data, mon_e.d);
         end
      end
   end

   task automatic gap(input int n);
      repeat (n) @(negedge clk);
   endtask

   // called at a falling edge; returns at the falling edge after the transfer
   task automatic send_byte(input logic [7:0] b);
      int waitc = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL in_ready_timeout: got in_ready=0 for byte 0x%02h, expected 1", b);
         in_valid = 1'b0;
         return;
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input vec_t v, input bit gaps);
      for (int i = 0; i < v.nb; i++) begin
         if (gaps) gap($urandom_range(0, 3));
         send_byte(v.bytes[(v.nb-1-i)*8 +: 8]);
      end
   endtask

   task automatic push_writes(input vec_t v);
      wr_t e;
      for (int i = 0; i < v.nw; i++) begin
         e.a = v.wa[i];
         e.d = v.wd[i];
         exp_q.push_back(e);
      end
   endtask

   task automatic check_end(input string tag, input logic d, input logic e, input logic r);
      gap(3);
      chk({tag, "_done"},     32'(done),      32'(d));
      chk({tag, "_error"},    32'(error),     32'(e));
      chk({tag, "_core_run"}, 32'(core_run),  32'(r));
      chk({tag, "_in_ready"}, 32'(in_ready),  32'(!(d || e)));
      chk({tag, "_pending"},  exp_q.size(),   32'd0);
      exp_q.delete();
   endtask

   task automatic restart_pulse();
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "_wr_en"},    32'(wr_en),    32'd0);
      chk({tag, "_wr_addr"},  32'(wr_addr),  32'd0);
      chk({tag, "_wr_data"},  wr_data,       32'd0);
      chk({tag, "_core_run"}, 32'(core_run), 32'd0);
      chk({tag, "_done"},     32'(done),     32'd0);
      chk({tag, "_error"},    32'(error),    32'd0);
   endtask

   task automatic set_vec(input int k, input string name, input logic [127:0] bytes, input int nb,
                          input logic d, input logic e, input logic r, input int nw,
                          input logic [1:0][9:0] wa, input logic [1:0][31:0] wd);
      vecs[k].name     = name;
      vecs[k].bytes    = bytes;
      vecs[k].nb       = nb;
      vecs[k].exp_done = d;
      vecs[k].exp_err  = e;
      vecs[k].exp_run  = r;
      vecs[k].nw       = nw;
      vecs[k].wa       = wa;
      vecs[k].wd       = wd;
   endtask

   initial begin
      logic [7:0]  csum;
      logic [31:0] w;
      wr_t         e;

      set_vec(0, "load",    128'hA5_02_00_13_00_00_00_93_00_50_00_D0, 12, 1'b1, 1'b0, 1'b1, 2,
              {10'd1, 10'd0}, {32'h00500093, 32'h00000013});
      set_vec(1, "badcsum", 128'hA5_02_00_13_00_00_00_93_00_50_00_D1, 12, 1'b0, 1'b1, 1'b0, 2,
              {10'd1, 10'd0}, {32'h00500093, 32'h00000013});
      set_vec(2, "zero_ok", 128'hA5_00_00_00, 4, 1'b1, 1'b0, 1'b1, 0, '0, '0);
      set_vec(3, "zero_bad", 128'hA5_00_00_01, 4, 1'b0, 1'b1, 1'b0, 0, '0, '0);
      set_vec(4, "overflow", 128'hA5_01_04, 3, 1'b0, 1'b1, 1'b0, 0, '0, '0);
      set_vec(5, "one_word", 128'hA5_01_00_EF_BE_AD_DE_22, 8, 1'b1, 1'b0, 1'b1, 1,
              {10'd0, 10'd0}, {32'h0, 32'hDEADBEEF});

      // power-on reset values
      gap(2);
      check_reset_outputs("por");
      rst = 1'b1;
      gap(1);

      // table of complete frames
      for (int k = 0; k < 6; k++) begin
         push_writes(vecs[k]);
         send_frame(vecs[k], 1'b0);
         $display("frame %s sent (%0d bytes)", vecs[k].name, vecs[k].nb);
         check_end(vecs[k].name, vecs[k].exp_done, vecs[k].exp_err, vecs[k].exp_run);
         restart_pulse();
         chk({vecs[k].name, "_restart_in_ready"}, 32'(in_ready), 32'd1);
      end

      // overflow flagged on the very cycle after LEN_HI is taken
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h04);
      chk("ovf_immediate_error",    32'(error),    32'd1);
      chk("ovf_immediate_in_ready", 32'(in_ready), 32'd0);
      restart_pulse();

      // leading junk, random gaps, then restart keeps core_run until next sync
      send_byte(8'h3C);
      send_byte(8'h00);
      push_writes(vecs[0]);
      send_frame(vecs[0], 1'b1);
      $display("frame gapped_load sent");
      check_end("gapped", 1'b1, 1'b0, 1'b1);
      restart_pulse();
      chk("restart_keeps_run",  32'(core_run), 32'd1);
      chk("restart_idle_ready", 32'(in_ready), 32'd1);
      send_byte(8'hA5);
      chk("sync_clears_run",    32'(core_run), 32'd0);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      check_end("after_sync", 1'b1, 1'b0, 1'b1);
      restart_pulse();

      // restart mid-DATA is ignored; the frame still completes
      push_writes(vecs[5]);
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'hEF);
      send_byte(8'hBE);
      restart_pulse();
      send_byte(8'hAD);
      send_byte(8'hDE);
      send_byte(8'h22);
      check_end("restart_ignored", 1'b1, 1'b0, 1'b1);

      // reset while DONE drops core_run and done
      rst = 1'b0;
      gap(1);
      check_reset_outputs("rst_done");
      rst = 1'b1;
      gap(1);

      // reset mid-DATA: partial word never written
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h11);
      send_byte(8'h22);
      rst = 1'b0;
      gap(1);
      check_reset_outputs("rst_mid");
      rst = 1'b1;
      gap(1);
      send_byte(8'h33);
      send_byte(8'h44);
      push_writes(vecs[5]);
      send_frame(vecs[5], 1'b0);
      check_end("post_reset", 1'b1, 1'b0, 1'b1);
      restart_pulse();

      // largest legal frame: N = 1024 fills every address
      send_byte(8'hA5);
      send_byte(8'h00);
      send_byte(8'h04);
      chk("max_len_no_error", 32'(error),    32'd0);
      chk("max_len_in_ready", 32'(in_ready), 32'd1);
      csum = 8'h00;
      for (int i = 0; i < 1024; i++) begin
         w   = $urandom();
         e.a = 10'(i);
         e.d = w;
         exp_q.push_back(e);
         for (int b = 0; b < 4; b++) begin
            csum = csum ^ w[8*b +: 8];
            send_byte(w[8*b +: 8]);
         end
      end
      send_byte(csum);
      check_end("max_len", 1'b1, 1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
